i2c_config_seq: RTL

I2C_CONFIG_SEQ -- requirements
Module: i2c_config_seq

---
 rtl/i2c_config_seq.sv | 139 +++++++++++++
 1 files changed

// File: rtl/i2c_config_seq.sv
// i2c_config_seq: drives a byte-oriented I2C master controller to write a table of
// register/data pairs to one slave, with NACK retry and sticky error reporting.
module i2c_config_seq #(
    parameter int          NUM_REGS  = 4,
    parameter logic [15:0] CLK_DIV   = 16'h0055,
    parameter int          MAX_RETRY = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] device_id,
    output logic [7:0] tbl_index,
    input  logic [7:0] tbl_reg,
    input  logic [7:0] tbl_data,
    output logic [7:0] i2c_din,
    output logic [2:0] i2c_addr,
    output logic       i2c_start,
    output logic       i2c_we,
    input  logic [7:0] i2c_dout,
    input  logic       i2c_done,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [7:0] err_index
);
    typedef enum logic [3:0] {IDLE, INIT, SEND_ID, SEND_REG, SEND_DATA, POLL, NEXT, ABORT, FIN, ERR} state_t;
    localparam logic [7:0] LAST = 8'(NUM_REGS - 1);
    localparam logic [7:0] MAXR = 8'(MAX_RETRY);
    state_t     state, state_nx, ret;
    logic [1:0] step, step_nx;
    logic [7:0] retry, a_din;
    logic [2:0] a_addr;
    logic       a_we, pend, fire, fin, tip, nack, last, unused;
    assign tip    = i2c_dout[1];
    assign nack   = i2c_dout[7];
    assign unused = ^{i2c_dout[6:2], i2c_dout[0]};
    assign fin    = pend & i2c_done;
    assign fire   = !pend && (state inside {INIT, SEND_ID, SEND_REG, SEND_DATA, POLL, ABORT});
    assign last   = tbl_index == LAST;
    assign busy   = state != IDLE;
    assign done   = state == FIN;
    // Every access is a single strobe followed by a wait on i2c_done; pend tracks the wait.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            step      <= 2'd0;
            ret       <= IDLE;
            pend      <= 1'b0;
            retry     <= 8'd0;
            tbl_index <= 8'd0;
            error     <= 1'b0;
            err_index <= 8'd0;
            i2c_start <= 1'b0;
            i2c_addr  <= 3'd0;
            i2c_din   <= 8'd0;
            i2c_we    <= 1'b0;
        end else begin
            state     <= state_nx;
            step      <= step_nx;
            pend      <= fire | (pend & ~i2c_done);
            i2c_start <= fire;
            if (fire) begin
                i2c_addr <= a_addr;
                i2c_din  <= a_din;
                i2c_we   <= a_we;
            end
            if (state != POLL && state_nx == POLL) ret <= state;
            if (state == IDLE && start) begin
                tbl_index <= 8'd0;
                retry     <= 8'd0;
                error     <= 1'b0;
            end
            if (state == NEXT) begin
                retry <= 8'd0;
                if (!last) tbl_index <= tbl_index + 8'd1;
            end
            if (state == ABORT && state_nx == SEND_ID) retry <= retry + 8'd1;
            if (state == ERR) begin
                error     <= 1'b1;
                err_index <= tbl_index;
            end
        end
    end
    always_comb begin
        state_nx = state;
        step_nx  = step;
        case (state)
            IDLE: if (start) state_nx = INIT;
            INIT: if (fin) begin
                step_nx = step + 2'd1;
                if (step == 2'd2) begin
                    state_nx = SEND_ID;
                    step_nx  = 2'd0;
                end
            end
            SEND_ID, SEND_REG, SEND_DATA: if (fin) begin
                step_nx = step + 2'd1;
                if (step == 2'd1) begin
                    state_nx = POLL;
                    step_nx  = 2'd0;
                end
            end
            POLL: if (fin && !tip) state_nx = nack ? ABORT : ret == SEND_ID ? SEND_REG : ret == SEND_REG ? SEND_DATA : NEXT;
            ABORT: if (fin) begin
                step_nx = 2'd1;
                if (step == 2'd1 && !tip) begin
                    state_nx = retry == MAXR ? ERR : SEND_ID;
                    step_nx  = 2'd0;
                end
            end
            NEXT: state_nx = last ? FIN : SEND_ID;
            default: state_nx = IDLE;
        endcase
    end
    // Step 0 of each send state loads the tx byte, step 1 issues the command.
    always_comb begin
        a_addr = 3'd4;
        a_din  = 8'h00;
        a_we   = 1'b0;
        case (state)
            INIT: begin
                a_addr = {1'b0, step};
                a_din  = step == 2'd0 ? CLK_DIV[7:0] : step == 2'd1 ? CLK_DIV[15:8] : 8'h80;
                a_we   = 1'b1;
            end
            SEND_ID, SEND_REG, SEND_DATA: begin
                a_addr = step == 2'd0 ? 3'd3 : 3'd4;
                a_din  = step != 2'd0 ? (state == SEND_ID ? 8'h90 : state == SEND_REG ? 8'h10 : 8'h50)
                                      : (state == SEND_ID ? device_id : state == SEND_REG ? tbl_reg : tbl_data);
                a_we   = 1'b1;
            end
            ABORT: begin
                a_din = step == 2'd0 ? 8'h40 : 8'h00;
                a_we  = step == 2'd0;
            end
            default: ;
        endcase
    end
endmodule
